// File: rtl/sfu_acc_act.sv
// Post-array special-function unit: per-column psum accumulation,
// saturation and activation behind valid/ready handshakes.
module sfu_acc_act #(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int CNT_BW   = 4,
  parameter int LEAKY_SH = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_mode_i,
  input  logic [1:0]             cfg_act_i,
  input  logic [CNT_BW-1:0]      cfg_len_i,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [col*psum_bw-1:0] psum_out,
  output logic [CNT_BW-1:0]      acc_cnt_o
);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

  localparam int VW = col * psum_bw;

  state_t              r_state;
  logic [CNT_BW-1:0]   r_cnt;
  logic [CNT_BW-1:0]   r_len;
  logic [1:0]          r_act;
  logic [VW-1:0]       r_acc;
  logic [VW-1:0]       r_out;
  logic                r_ovalid;

  logic                w_idle;
  logic [CNT_BW-1:0]   w_len;
  logic [CNT_BW-1:0]   w_cnt_nx;
  logic [1:0]          w_act;
  logic                w_beat;
  logic                w_fin;
  logic [VW-1:0]       w_sum;
  logic [VW-1:0]       w_actv;

  assign w_idle   = (r_state == S_IDLE);
  assign w_cnt_nx = r_cnt + CNT_BW'(1);

  // First beat of a group takes config from the inputs directly
  always_comb begin
    w_len = r_len;
    w_act = r_act;
    if (w_idle) begin
      w_act = cfg_act_i;
      if (cfg_mode_i || (cfg_len_i == '0))
        w_len = CNT_BW'(1);
      else
        w_len = cfg_len_i;
    end
  end

  assign in_ready_o  = ~clear_i & (~r_ovalid | out_ready_i);
  assign w_beat      = in_valid_i & in_ready_o;
  assign w_fin       = (w_cnt_nx == w_len);
  assign out_valid_o = r_ovalid;
  assign psum_out    = r_out;
  assign acc_cnt_o   = r_cnt;

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic signed [psum_bw-1:0] w_a;
    logic signed [psum_bw-1:0] w_b;
    logic signed [psum_bw:0]   w_s;
    logic signed [psum_bw-1:0] w_sat;
    logic signed [psum_bw-1:0] w_o;

    assign w_a = r_acc[k*psum_bw +: psum_bw];
    assign w_b = psum_in[k*psum_bw +: psum_bw];
    assign w_s = {w_a[psum_bw-1], w_a} + {w_b[psum_bw-1], w_b};

    // Top two bits disagree only on overflow
    always_comb begin
      w_sat = w_s[psum_bw-1:0];
      if (w_s[psum_bw] != w_s[psum_bw-1])
        w_sat = w_s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                             : {1'b0, {(psum_bw-1){1'b1}}};
    end

    always_comb begin
      w_o = w_sat;
      case (w_act)
        2'b01: if (w_sat[psum_bw-1]) w_o = '0;
        2'b10: if (w_sat[psum_bw-1]) w_o = w_sat >>> LEAKY_SH;
        default: w_o = w_sat;
      endcase
    end

    assign w_sum[k*psum_bw +: psum_bw]  = w_sat;
    assign w_actv[k*psum_bw +: psum_bw] = w_o;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_act    <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (clear_i) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= S_IDLE;
      end else if (w_beat) begin
        if (w_idle) begin
          r_len <= w_len;
          r_act <= cfg_act_i;
        end
        if (w_fin) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_acc   <= w_sum;
          r_cnt   <= w_cnt_nx;
          r_state <= S_ACC;
        end
      end
      if (w_beat && w_fin) begin
        r_out    <= w_actv;
        r_ovalid <= 1'b1;
      end else if (out_ready_i) begin
        r_ovalid <= 1'b0;
      end
    end
  end

endmodule
